// File: rtl/usb_line_arb.sv
// usb_line_arb: USB half-duplex line arbiter with inter-packet gap and response timeout (USB_LINE_ARB_TIMEOUT_EN).
module usb_line_arb #(
  parameter int CLK_PER_BIT  = 4,
  parameter int IPD_BITS     = 2,
  parameter int TIMEOUT_BITS = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_active,
  input  logic rx_error,
  input  logic tx_req,
  input  logic tx_resp_exp,
  input  logic tx_done,
  output logic tx_grant,
  output logic tx_oe,
  output logic rx_en,
  output logic bus_busy,
  output logic rx_timeout,
  output logic rx_abort
);
  localparam int GAP  = IPD_BITS * CLK_PER_BIT;
  localparam int TOC  = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int MAXC = (IPD_BITS > TIMEOUT_BITS ? IPD_BITS : TIMEOUT_BITS) * CLK_PER_BIT;
  localparam int W    = $clog2(MAXC) + 1;
  typedef enum logic [2:0] {IDLE, RX, RX_GAP, TX, TX_GAP, RESP_WAIT} state_e;
  state_e state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, resp_q, resp_d, abort_d, gap_done;
  assign gap_done = cnt_q == W'(GAP - 1);
`ifdef USB_LINE_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  logic to_d;
  assign to_d = state_q == RESP_WAIT && !rx_active && cnt_q == W'(TOC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_timeout <= 1'b0;
    else rx_timeout <= to_d;
`else
  localparam bit TO_EN = 1'b0;
  assign rx_timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    resp_d  = resp_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = rx_active ? RX : tx_req ? TX : IDLE;
        resp_d  = (!rx_active && tx_req) ? tx_resp_exp : resp_q;
      end
      RX: begin
        err_d = err_q | rx_error;
        if (!rx_active) begin
          state_d = RX_GAP;
          abort_d = err_d;
          err_d   = 1'b0;
        end
      end
      // Expiry hands straight to a waiting transmitter so the hold-off is exactly GAP cycles.
      RX_GAP: begin
        state_d = rx_active ? RX : !gap_done ? RX_GAP : tx_req ? TX : IDLE;
        resp_d  = (!rx_active && gap_done && tx_req) ? tx_resp_exp : resp_q;
      end
      TX:        state_d = tx_done ? TX_GAP : TX;
      TX_GAP:    state_d = rx_active ? RX : !gap_done ? TX_GAP : (TO_EN && resp_q) ? RESP_WAIT : IDLE;
      RESP_WAIT: state_d = rx_active ? RX : cnt_q == W'(TOC - 1) ? IDLE : RESP_WAIT;
      default:   state_d = IDLE;
    endcase
  end
  assign cnt_d = (state_d != state_q) ? '0 : cnt_q + {{(W-1){1'b0}}, ~&cnt_q};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      resp_q   <= 1'b0;
      tx_grant <= 1'b0;
      tx_oe    <= 1'b0;
      rx_en    <= 1'b1;
      bus_busy <= 1'b0;
      rx_abort <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      resp_q   <= resp_d;
      tx_grant <= state_d == TX;
      tx_oe    <= state_d == TX;
      rx_en    <= state_d != TX;
      bus_busy <= state_d != IDLE;
      rx_abort <= abort_d;
    end
  end
endmodule

// File: doc/usb_line_arb.md
USB_LINE_ARB -- requirements
Module: usb_line_arb

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 4, meaning clk cycles per USB bit time (4x oversampling).
REQ-002 SHALL have parameter IPD_BITS, default 2, meaning the minimum inter-packet gap in bit times.
REQ-003 SHALL have parameter TIMEOUT_BITS, default 18, meaning the response timeout in bit times.
REQ-004 SHALL have port clk  in  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port rx_active  in  1  receive state machine active, from the UTM receiver.
REQ-007 SHALL have port rx_error  in  1  receive error, from the UTM receiver.
REQ-008 SHALL have port tx_req  in  1  SIE requests the line for transmit; level, held until granted.
REQ-009 SHALL have port tx_resp_exp  in  1  the granted packet expects a response; sampled at grant.
REQ-010 SHALL have port tx_done  in  1  one-cycle pulse, transmitter finished EOP.
REQ-011 SHALL have port tx_grant  out  1  SIE may transmit.
REQ-012 SHALL have port tx_oe  out  1  line driver output enable.
REQ-013 SHALL have port rx_en  out  1  receiver enable; low while driving.
REQ-014 SHALL have port bus_busy  out  1  high in any state other than IDLE.
REQ-015 SHALL have port rx_timeout  out  1  one-cycle pulse, expected response not started.
REQ-016 SHALL have port rx_abort  out  1  one-cycle pulse on the falling rx_active of an errored packet.

Function
REQ-017 SHALL implement states IDLE, RX, RX_GAP, TX, TX_GAP and RESP_WAIT; all outputs are registered.
REQ-018 IDLE: rx_active=1 SHALL move to RX next cycle; rx_active wins over a simultaneous tx_req.
REQ-019 IDLE: tx_req=1 with rx_active=0 SHALL move to TX; tx_grant=tx_oe=1 and rx_en=0 from the next cycle; latch tx_resp_exp.
REQ-020 RX: SHALL set a sticky error flag on any rx_error=1; on rx_active falling SHALL move to RX_GAP and pulse rx_abort if the flag is set, then clear the flag.
REQ-021 RX_GAP: SHALL hold off tx_req for exactly IPD_BITS*CLK_PER_BIT cycles, then move to IDLE.
REQ-022 RX_GAP: rx_active=1 SHALL move to RX immediately and restart the gap on its next exit.
REQ-023 TX: SHALL ignore rx_active and keep rx_en=0 until tx_done; on tx_done move to TX_GAP, with tx_grant, tx_oe deasserted and rx_en asserted the next cycle.
REQ-024 TX_GAP: SHALL count IPD_BITS*CLK_PER_BIT cycles; rx_active=1 SHALL move to RX.
REQ-025 TX_GAP: on expiry SHALL move to RESP_WAIT if the latched tx_resp_exp=1, else to IDLE.
REQ-026 RESP_WAIT: rx_active=1 SHALL move to RX.
REQ-027 RESP_WAIT: after TIMEOUT_BITS*CLK_PER_BIT cycles SHALL pulse rx_timeout for one cycle and move to IDLE.
REQ-028 rx_active and timer expiry in the same cycle SHALL favour rx_active: go to RX with no rx_timeout.
REQ-029 The gap/timeout counter SHALL be sized to clog2(max(IPD_BITS,TIMEOUT_BITS)*CLK_PER_BIT)+1 bits, clear on every state entry and never wrap.
REQ-030 rx_en SHALL be 1 in every state except TX.
REQ-031 A tx_done outside TX SHALL be ignored.

Reset
REQ-032 rst SHALL force IDLE immediately, including mid-TX or mid-RX.
REQ-033 Reset values: tx_grant=0, tx_oe=0, rx_en=1, bus_busy=0, rx_timeout=0, rx_abort=0, counter=0, error flag=0.
REQ-034 After reset release, a held tx_req SHALL be granted one cycle later if rx_active=0.

Configuration
REQ-035 USB_LINE_ARB_TIMEOUT_EN defined: RESP_WAIT and rx_timeout are implemented as above.
REQ-036 USB_LINE_ARB_TIMEOUT_EN undefined: TX_GAP expiry always goes to IDLE, and rx_timeout is tied to 0.

Verification
REQ-037 Reset mid-TX (tx_oe=1), assert rst -> tx_oe=0 and rx_en=1 asynchronously; after release with tx_req held, tx_grant=1 one cycle later.
REQ-038 In IDLE, raise tx_req and rx_active in the same cycle -> state RX, tx_grant stays 0 through RX and 8 gap cycles, then is granted.
REQ-039 RX packet ends (rx_active 1->0) with tx_req held -> tx_grant rises exactly 8 cycles (IPD 2 x 4) after entering RX_GAP.
REQ-040 TX with tx_resp_exp=1, tx_done, no rx_active -> rx_timeout pulses once, 8+72 cycles after TX_GAP entry (macro on); no pulse with macro off.
REQ-041 rx_error pulse mid-RX, then rx_active falls -> single rx_abort pulse; the next clean packet produces no rx_abort.
